// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared game-state encodings and defaults for the pong controller
//
// Contents:
//   gstate_t        2-bit game state (NEWGAME/PLAY/NEWBALL/OVER)
//   BALLS_DEF       default balls per game
//   WAIT_FRAMES_DEF default inter-ball / game-over wait in frames
//   BCD_W           width of one BCD score digit
package pong_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'b00,
        ST_PLAY    = 2'b01,
        ST_NEWBALL = 2'b10,
        ST_OVER    = 2'b11
    } gstate_t;

    localparam int BALLS_DEF       = 3;
    localparam int WAIT_FRAMES_DEF = 120;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;
    localparam logic [BCD_W-1:0] BCD_ONE  = 4'd1;
    localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

endpackage

// File: rtl/pong_m100_counter.sv
// rtl/pong_m100_counter.sv - two-digit BCD counter wrapping 99 -> 00
//
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-high reset, digits to 00
//   d_clr  in   clear both digits on the next edge (wins over d_inc)
//   d_inc  in   advance the count by one on the next edge
//   dig0   out  units digit, BCD
//   dig1   out  tens digit, BCD
module pong_m100_counter
    import pong_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             d_clr,
    input  logic             d_inc,
    output logic [BCD_W-1:0] dig0,
    output logic [BCD_W-1:0] dig1
);

    logic [BCD_W-1:0] dig0_q, dig0_d;
    logic [BCD_W-1:0] dig1_q, dig1_d;

    always_comb begin
        dig0_d = dig0_q;
        dig1_d = dig1_q;
        if (d_clr) begin
            dig0_d = BCD_ZERO;
            dig1_d = BCD_ZERO;
        end else if (d_inc) begin
            if (dig0_q == BCD_NINE) begin
                dig0_d = BCD_ZERO;
                // Tens digit wraps silently; the score is mod 100.
                dig1_d = (dig1_q == BCD_NINE) ? BCD_ZERO : dig1_q + BCD_ONE;
            end else begin
                dig0_d = dig0_q + BCD_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dig0_q <= BCD_ZERO;
            dig1_q <= BCD_ZERO;
        end else begin
            dig0_q <= dig0_d;
            dig1_q <= dig1_d;
        end
    end

    assign dig0 = dig0_q;
    assign dig1 = dig1_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game-flow controller: state machine, score, balls, frame timer
//
// Ports:
//   clk          in   25 MHz pixel clock
//   reset        in   asynchronous active-high reset
//   frame_tick   in   one-cycle pulse per frame
//   btn[1:0]     in   paddle buttons, any nonzero value is a press
//   hit          in   one-cycle pulse, ball hit the paddle
//   miss         in   one-cycle pulse, ball passed the paddle
//   dig0[3:0]    out  score units digit, BCD
//   dig1[3:0]    out  score tens digit, BCD
//   ball[1:0]    out  balls remaining
//   timer[6:0]   out  frame countdown
//   timer_up     out  timer has reached zero
//   gstate[1:0]  out  current game state
//   graph_still  out  freeze ball animation
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int BALLS       = BALLS_DEF,
    parameter int WAIT_FRAMES = WAIT_FRAMES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic [1:0]       btn,
    input  logic             hit,
    input  logic             miss,
    output logic [BCD_W-1:0] dig0,
    output logic [BCD_W-1:0] dig1,
    output logic [1:0]       ball,
    output logic [6:0]       timer,
    output logic             timer_up,
    output logic [1:0]       gstate,
    output logic             graph_still
);

    localparam logic [1:0] BALLS_INIT = 2'(BALLS);
    localparam logic [6:0] WAIT_INIT  = 7'(WAIT_FRAMES);

    gstate_t    state_q;
    logic [1:0] ball_q;
    logic       graph_still_q;
    logic [6:0] timer_q, timer_d;

    logic btn_any;
    logic timer_zero;
    logic timer_load;
    logic score_clr;
    logic score_inc;

    assign btn_any    = |btn;
    assign timer_zero = (timer_q == 7'd0);

    // Side effects decoded from the current state so they line up with the
    // transition taken on the same edge.
    assign score_clr  = (state_q == ST_NEWGAME) && btn_any;
    assign score_inc  = (state_q == ST_PLAY) && hit;
    assign timer_load = (state_q == ST_PLAY) && miss;

    // Frame countdown: load has priority over a coincident frame_tick,
    // and the count parks at zero.
    always_comb begin
        timer_d = timer_q;
        if (timer_load) begin
            timer_d = WAIT_INIT;
        end else if (frame_tick && !timer_zero) begin
            timer_d = timer_q - 7'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= WAIT_INIT;
        end else begin
            timer_q <= timer_d;
        end
    end

    // Game FSM with the ball count and freeze control registered alongside.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_NEWGAME;
            ball_q        <= BALLS_INIT;
            graph_still_q <= 1'b1;
        end else begin
            case (state_q)
                ST_NEWGAME: begin
                    if (btn_any) begin
                        ball_q        <= BALLS_INIT;
                        state_q       <= ST_PLAY;
                        graph_still_q <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (miss) begin
                        ball_q        <= ball_q - 2'd1;
                        graph_still_q <= 1'b1;
                        state_q       <= (ball_q == 2'd1) ? ST_OVER : ST_NEWBALL;
                    end
                end
                ST_NEWBALL: begin
                    // Presses before the wait expires are deliberately not latched.
                    if (timer_zero && btn_any) begin
                        state_q       <= ST_PLAY;
                        graph_still_q <= 1'b0;
                    end
                end
                ST_OVER: begin
                    // Score and ball=0 stay visible until the next game start.
                    if (timer_zero) begin
                        state_q <= ST_NEWGAME;
                    end
                end
                default: begin
                    state_q       <= ST_NEWGAME;
                    graph_still_q <= 1'b1;
                end
            endcase
        end
    end

    pong_m100_counter u_score (
        .clk   (clk),
        .reset (reset),
        .d_clr (score_clr),
        .d_inc (score_inc),
        .dig0  (dig0),
        .dig1  (dig1)
    );

    assign ball        = ball_q;
    assign timer       = timer_q;
    assign timer_up    = timer_zero;
    assign gstate      = state_q;
    assign graph_still = graph_still_q;

endmodule
